// File: rtl/instruction_decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready on both sides,
// conditional-jump stall on stale flags, circular return-address stack, wrong-path squash.
module instruction_decode_stage #(
  parameter int unsigned INS_W       = 21,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INS_W-1:0]             ins,
  input  logic [ADDR_W-1:0]            ins_addr,
  input  logic [4:0]                   flags,
  input  logic                         flags_valid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         A_ce,
  output logic                         REGS_ce,
  output logic                         flags_ce,
  output logic                         load_pc,
  output logic                         PC_source,
  output logic                         block_cy_ov,
  output logic                         mem_we,
  output logic [1:0]                   arg_source,
  output logic [2:0]                   opcode,
  output logic [ADDR_W-1:0]            new_pc,
  output logic [ADDR_W-1:0]            instant,
  output logic [REG_AW-1:0]            REGS_addr,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic [$clog2(STACK_DEPTH):0] stack_level,
  output logic                         stack_err
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH);
  localparam int unsigned LVL_W = SP_W + 1;

  localparam logic [4:0] OP_JMP  = 5'b01001;
  localparam logic [4:0] OP_CALL = 5'b01101;
  localparam logic [4:0] OP_JZ   = 5'b01010;
  localparam logic [4:0] OP_CZ   = 5'b01110;
  localparam logic [4:0] OP_JOV  = 5'b01011;
  localparam logic [4:0] OP_COV  = 5'b01111;
  localparam logic [4:0] OP_RET  = 5'b10001;

  logic [4:0]        op;
  logic              flag_z;
  logic              flag_ov;
  logic              unused_flags;
  logic              is_cond;
  logic              cond_stall;
  logic              discard;
  logic              accept;
  logic              load;

  logic              squash;
  logic [ADDR_W-1:0] target;

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] push_val;

  logic              jump;
  logic              call;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              d_a_ce;
  logic              d_regs_ce;
  logic              d_flags_ce;
  logic              d_load_pc;
  logic              d_pc_source;
  logic              d_block_cy_ov;
  logic              d_mem_we;
  logic [1:0]        d_arg_source;
  logic [ADDR_W-1:0] d_new_pc;

  assign op           = ins[INS_W-1 -: 5];
  assign flag_z       = flags[4];
  assign flag_ov      = flags[0];
  assign unused_flags = ^flags[3:1];
  assign stack_top    = stack_mem[sp - SP_W'(1)];
  assign push_val     = ins_addr + ADDR_W'(1);

  // Handshake: conditional jumps wait for settled flags unless the beat is wrong-path
  always_comb begin
    is_cond    = (op == OP_JZ) || (op == OP_CZ) || (op == OP_JOV) || (op == OP_COV);
    cond_stall = in_valid && is_cond && !flags_valid && !squash;
    in_ready   = (!out_valid || out_ready) && !cond_stall;
    discard    = squash && (ins_addr != target);
    accept     = in_valid && in_ready;
    load       = accept && !discard;
  end

  // Opcode decode; stack effects are only committed when the beat loads
  always_comb begin
    jump          = 1'b0;
    call          = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    err_set       = 1'b0;
    d_a_ce        = 1'b0;
    d_regs_ce     = 1'b0;
    d_flags_ce    = 1'b0;
    d_load_pc     = 1'b0;
    d_pc_source   = 1'b0;
    d_block_cy_ov = 1'b0;
    d_mem_we      = 1'b0;
    d_arg_source  = 2'b00;
    d_new_pc      = '0;
    case (op)
      5'b00000, 5'b00100, 5'b01000, 5'b01100, 5'b10000, 5'b10100: begin
        d_a_ce     = 1'b1;
        d_flags_ce = 1'b1;
      end
      5'b00001, 5'b00101: begin
        d_a_ce        = 1'b1;
        d_flags_ce    = 1'b1;
        d_arg_source  = 2'b01;
        d_block_cy_ov = 1'b1;
      end
      OP_JMP:  jump = 1'b1;
      OP_CALL: begin jump = 1'b1; call = 1'b1; end
      OP_JZ:   jump = flag_z;
      OP_CZ:   begin jump = flag_z; call = flag_z; end
      OP_JOV:  jump = flag_ov;
      OP_COV:  begin jump = flag_ov; call = flag_ov; end
      OP_RET: begin
        if (stack_level != '0) begin
          d_load_pc = 1'b1;
          d_new_pc  = stack_top;
          pop       = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
      5'b11100, 5'b11101, 5'b11110: begin
        d_a_ce        = 1'b1;
        d_pc_source   = 1'b1;
        d_arg_source  = op[1:0];
        d_block_cy_ov = 1'b1;
      end
      5'b11001, 5'b11010: begin
        d_regs_ce     = op[0];
        d_mem_we      = op[1];
        d_pc_source   = 1'b1;
        d_arg_source  = 2'b01;
        d_block_cy_ov = 1'b1;
      end
      default: ;
    endcase
    if (jump) begin
      d_load_pc     = 1'b1;
      d_new_pc      = ins[ADDR_W-1:0];
      d_arg_source  = 2'b01;
      d_block_cy_ov = 1'b1;
      push          = call;
    end
  end

  // Output registers, squash tracking and stack pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      A_ce        <= 1'b0;
      REGS_ce     <= 1'b0;
      flags_ce    <= 1'b0;
      load_pc     <= 1'b0;
      PC_source   <= 1'b0;
      block_cy_ov <= 1'b0;
      mem_we      <= 1'b0;
      arg_source  <= 2'b00;
      opcode      <= '0;
      new_pc      <= '0;
      instant     <= '0;
      REGS_addr   <= '0;
      mem_addr    <= '0;
      squash      <= 1'b0;
      target      <= '0;
      sp          <= '0;
      stack_level <= '0;
      stack_err   <= 1'b0;
    end else begin
      if (load) begin
        out_valid   <= 1'b1;
        A_ce        <= d_a_ce;
        REGS_ce     <= d_regs_ce;
        flags_ce    <= d_flags_ce;
        load_pc     <= d_load_pc;
        PC_source   <= d_pc_source;
        block_cy_ov <= d_block_cy_ov;
        mem_we      <= d_mem_we;
        arg_source  <= d_arg_source;
        opcode      <= ins[INS_W-1 -: 3];
        new_pc      <= d_new_pc;
        instant     <= ins[ADDR_W-1:0];
        REGS_addr   <= ins[REG_AW-1:0];
        mem_addr    <= ins[MEM_AW-1:0];
        squash      <= d_load_pc;
        if (d_load_pc) target <= d_new_pc;
        if (push) begin
          sp <= sp + SP_W'(1);
          if (stack_level == LVL_W'(STACK_DEPTH)) stack_err <= 1'b1;
          else stack_level <= stack_level + LVL_W'(1);
        end else if (pop) begin
          sp          <= sp - SP_W'(1);
          stack_level <= stack_level - LVL_W'(1);
        end
        if (err_set) stack_err <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Stack storage; a push into a full stack lands on the oldest slot
  always_ff @(posedge clk) begin
    if (load && push) stack_mem[sp] <= push_val;
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed bench for instruction_decode_stage: driver pushes expected beats into a
// queue, an independent monitor pops and compares every accepted output beat.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] ins;
  logic [15:0] ins_addr;
  logic [4:0]  flags;
  logic        flags_valid;
  logic        out_valid;
  logic        out_ready;
  logic        A_ce, REGS_ce, flags_ce, load_pc, PC_source, block_cy_ov, mem_we;
  logic [1:0]  arg_source;
  logic [2:0]  opcode;
  logic [15:0] new_pc;
  logic [15:0] instant;
  logic [4:0]  REGS_addr;
  logic [9:0]  mem_addr;
  logic [2:0]  stack_level;
  logic        stack_err;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .ins_addr(ins_addr), .flags(flags), .flags_valid(flags_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .A_ce(A_ce), .REGS_ce(REGS_ce), .flags_ce(flags_ce), .load_pc(load_pc),
    .PC_source(PC_source), .block_cy_ov(block_cy_ov), .mem_we(mem_we),
    .arg_source(arg_source), .opcode(opcode), .new_pc(new_pc), .instant(instant),
    .REGS_addr(REGS_addr), .mem_addr(mem_addr), .stack_level(stack_level),
    .stack_err(stack_err)
  );

  typedef struct packed {
    logic [8:0]  ctrl;  // {A_ce,REGS_ce,flags_ce,load_pc,PC_source,block_cy_ov,mem_we,arg_source}
    logic [2:0]  opc;
    logic [15:0] npc;
    logic [15:0] imm;
    logic [4:0]  ra;
    logic [9:0]  ma;
  } beat_t;

  localparam logic [8:0] C_NOP = 9'b000000000;
  localparam logic [8:0] C_ALU = 9'b101000000;
  localparam logic [8:0] C_INC = 9'b101001001;
  localparam logic [8:0] C_JMP = 9'b000101001;
  localparam logic [8:0] C_RET = 9'b000100000;
  localparam logic [8:0] C_LDA = 9'b100011001;
  localparam logic [8:0] C_ST  = 9'b000011101;
  localparam logic [8:0] C_REG = 9'b010011001;
  localparam logic [4:0] FZ    = 5'b10000;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each beat on the cycle execute takes it
  always @(negedge clk) begin
    beat_t act;
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      act = {A_ce, REGS_ce, flags_ce, load_pc, PC_source, block_cy_ov, mem_we, arg_source,
             opcode, new_pc, instant, REGS_addr, mem_addr};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h expected no output", act);
      end else begin
        e = exp_q.pop_front();
        if (!e.ctrl[5]) begin
          act.npc = '0;
          e.npc   = '0;
        end
        if (act !== e) begin
          errors++;
          $display("FAIL beat: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [15:0] imm, input logic [15:0] addr,
                      input logic [4:0] fl, input logic fv, input logic exp_out,
                      input logic [8:0] ctrl, input logic [15:0] npc);
    bit ok;
    ok          = 1'b0;
    ins         = {op, imm};
    ins_addr    = addr;
    flags       = fl;
    flags_valid = fv;
    in_valid    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h: in_ready got 0 expected 1", addr);
    end else if (exp_out) begin
      exp_q.push_back({ctrl, op[4:2], npc, imm, imm[4:0], imm[9:0]});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] r;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ins         = '0;
    ins_addr    = '0;
    flags       = '0;
    flags_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a_ce", 32'(A_ce), 32'd0);
    check("rst_load_pc", 32'(load_pc), 32'd0);
    check("rst_stack_level", 32'(stack_level), 32'd0);
    check("rst_stack_err", 32'(stack_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Plain decode classes
    send(5'b00100, 16'h1234, 16'h0000, 5'd0, 1'b1, 1'b1, C_ALU, 16'h0);
    send(5'b00001, 16'h00AB, 16'h0001, 5'd0, 1'b1, 1'b1, C_INC, 16'h0);
    send(5'b11101, 16'h0155, 16'h0002, 5'd0, 1'b1, 1'b1, C_LDA, 16'h0);
    send(5'b11010, 16'h03C7, 16'h0003, 5'd0, 1'b1, 1'b1, C_ST,  16'h0);
    send(5'b11001, 16'h001F, 16'h0004, 5'd0, 1'b1, 1'b1, C_REG, 16'h0);
    send(5'b11111, 16'hBEEF, 16'h0005, 5'd0, 1'b1, 1'b1, C_NOP, 16'h0);

    // CALL then RET
    send(5'b01101, 16'h0040, 16'h0010, 5'd0, 1'b1, 1'b1, C_JMP, 16'h0040);
    check("call_level", 32'(stack_level), 32'd1);
    send(5'b10001, 16'h0000, 16'h0040, 5'd0, 1'b1, 1'b1, C_RET, 16'h0011);
    check("ret_level", 32'(stack_level), 32'd0);
    send(5'b00000, 16'h0007, 16'h0011, 5'd0, 1'b1, 1'b1, C_ALU, 16'h0);

    // JZ waits for flags_valid
    ins         = {5'b01010, 16'h0200};
    ins_addr    = 16'h0012;
    flags       = 5'd0;
    flags_valid = 1'b0;
    in_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("jz_stall_in_ready", 32'(in_ready), 32'd0);
    end
    send(5'b01010, 16'h0200, 16'h0012, FZ, 1'b1, 1'b1, C_JMP, 16'h0200);

    // JMP then wrong-path beats (including an unstalled JZ) before the target
    send(5'b01001, 16'h0100, 16'h0200, 5'd0, 1'b1, 1'b1, C_JMP, 16'h0100);
    send(5'b00100, 16'h1111, 16'h0005, 5'd0, 1'b1, 1'b0, C_ALU, 16'h0);
    send(5'b01010, 16'h2222, 16'h0006, 5'd0, 1'b0, 1'b0, C_NOP, 16'h0);
    send(5'b00100, 16'h3333, 16'h0100, 5'd0, 1'b1, 1'b1, C_ALU, 16'h0);
    send(5'b01011, 16'h0777, 16'h0101, FZ,   1'b1, 1'b1, C_NOP, 16'h0);

    // Five nested CALLs overflow a 4-deep stack
    for (int k = 0; k < 5; k++) begin
      a = 16'h0300 + 16'(16 * k);
      send(5'b01101, a + 16'h0010, a, 5'd0, 1'b1, 1'b1, C_JMP, a + 16'h0010);
      if (k == 3) begin
        check("call4_err", 32'(stack_err), 32'd0);
        check("call4_level", 32'(stack_level), 32'd4);
      end
    end
    check("call5_err", 32'(stack_err), 32'd1);
    check("call5_level", 32'(stack_level), 32'd4);

    a = 16'h0350;
    for (int j = 0; j < 4; j++) begin
      r = 16'h0341 - 16'(16 * j);
      send(5'b10001, 16'h0000, a, 5'd0, 1'b1, 1'b1, C_RET, r);
      a = r;
    end
    send(5'b10001, 16'h0000, 16'h0311, 5'd0, 1'b1, 1'b1, C_NOP, 16'h0);
    check("ret5_level", 32'(stack_level), 32'd0);
    check("ret5_err", 32'(stack_err), 32'd1);

    // Output stall, then reset mid-stall
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(5'b01101, 16'h0410, 16'h0400, 5'd0, 1'b1, 1'b1, C_JMP, 16'h0410);
    ins      = {5'b00100, 16'h0410};
    ins_addr = 16'h0410;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_new_pc", 32'(new_pc), 32'h0410);
      check("stall_level", 32'(stack_level), 32'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_level", 32'(stack_level), 32'd0);
    check("midrst_err", 32'(stack_err), 32'd0);
    check("midrst_load_pc", 32'(load_pc), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(5'b10100, 16'h0ACE, 16'h0500, 5'd0, 1'b1, 1'b1, C_ALU, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
